ctr_updown_mod: RTL and testbench
=================================

// Module: ctr_updown_mod
// PURPOSE
//  Parametrised successor to the team's 8-bit loadable free-running counter. Adds
//  width/prescaler generics, up/down direction, a programmable modulus limit,
//  wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
//  Sits behind the top-level pin wrapper as the general counter/timer core.
// PARAMETERS
//  WIDTH       8   counter, load value and limit width (bits), >=2
//  PRE_W       4   prescale compare width; step every (prescale+1) enabled cycles
//  RST_VAL     0   count value after reset (WIDTH bits, must be <= 2^WIDTH-1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  en         in   1      count enable; low freezes count and prescaler
//  load       in   1      synchronous load of load_val
//  load_val   in   WIDTH  value written by load
//  up         in   1      1 = count up, 0 = count down
//  sat        in   1      0 = wrap at bounds, 1 = saturate at bounds
//  limit      in   WIDTH  upper bound (inclusive); range is 0..limit
//  prescale   in   PRE_W  prescaler compare value
//  clr_ovf    in   1      clears ovf_sticky
//  count      out  WIDTH  current count (registered)
//  tc         out  1      terminal-count pulse, 1 cycle (registered)
//  ovf_sticky out  1      set on any boundary event, held until clr_ovf
// BEHAVIOUR
//  Reset (async, active-high): count=RST_VAL, tc=0, ovf_sticky=0, prescaler=0.
//  Priority per edge: rst > load > tick step > hold.
//  Prescaler: pre_cnt increments on en; tick = en && (pre_cnt >= prescale);
//   on tick pre_cnt<=0. '>=' so lowering prescale mid-run ticks next en cycle.
//   prescale=0, en=1 -> count steps every cycle (1-cycle latency en->count).
//  load: count<=load_val, pre_cnt<=0, tc<=0; no boundary event even if
//   load_val>limit. load ignores en.
//  Step on tick, up=1: count>=limit -> boundary; else count+1.
//  Step on tick, up=0: count==0 -> boundary; else count-1 (count>limit just
//   decrements normally).
//  Boundary: sat=0 -> up wraps to 0, down wraps to limit.
//            sat=1 -> up holds at limit, down holds at 0.
//   Boundary sets tc=1 for exactly the cycle after the step edge (also when
//   saturated and holding: tc pulses on every tick while pinned) and sets
//   ovf_sticky.
//  tc=0 on every edge without a boundary step (includes en=0 cycles).
//  clr_ovf and boundary on same edge: set wins (ovf_sticky=1).
//  limit=0: up and down both boundary on every tick; count stays 0.
//  Direction/limit/sat changes take effect on the next tick; no pipeline.
//  Arithmetic is modulo 2^WIDTH internally; limit=2^WIDTH-1 gives full range.
//  rst mid-count: all state cleared immediately, no tc emitted.
// STRUCTURE
//  Package ctr_pkg: localparams CTR_UP=1'b1, CTR_DOWN=1'b0, CTR_WRAP=1'b0,
//   CTR_SAT=1'b1; shared by this block and future multi-channel timers.
//  Sub-module ctr_prescaler #(PRE_W): clk, rst, en, clr, prescale -> tick.
//   clr driven by load. Remaining next-state logic lives in this module.
// TESTING
//  1 WIDTH=8, prescale=0, up=1, sat=0, limit=9, en=1 from 0: counts 0..9,0;
//    tc high only the cycle count shows 0 after 9; ovf_sticky=1.
//  2 prescale=3, en=1: count advances once per 4 clocks; en low 2 cycles
//    mid-period stretches that period to 6 clocks.
//  3 up=0, sat=1, load_val=2: 2,1,0,0,0; tc pulses on each held tick at 0.
//  4 load_val=200, limit=9, up=1: next tick -> 0 with tc; up=0 instead ->
//    199, no tc.
//  5 clr_ovf asserted on same edge as boundary: ovf_sticky=1; clr_ovf alone
//    next edge: 0.
//  6 rst asserted asynchronously mid-prescale-period: count=RST_VAL, tc=0,
//    ovf_sticky=0 before next clk edge; first step after release needs full
//    prescale+1 enabled cycles.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared counter/timer encodings for direction and bound-handling mode.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ctr_pkg;

  localparam logic CTR_UP   = 1'b1;
  localparam logic CTR_DOWN = 1'b0;
  localparam logic CTR_WRAP = 1'b0;
  localparam logic CTR_SAT  = 1'b1;

endpackage

// File: rtl/ctr_prescaler.sv
// Prescaler: emits tick once every (prescale+1) enabled cycles.
// Latency: tick is combinational from en and the registered phase counter.
// Backpressure: none; en low freezes the phase, clr restarts the period.
module ctr_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // '>=' rather than '==' so that lowering prescale below the current phase
  // fires on the next enabled cycle instead of running the counter round.
  assign tick = en && (pre_cnt_q >= prescale);

  // Phase next-state: restart on clr or tick, advance only when enabled.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr || tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/ctr_updown_mod.sv
// Loadable up/down modulus counter with prescaler, wrap/saturate, tc and sticky overflow.
// Latency: 1 cycle from a tick (or load) to count/tc/ovf_sticky.
// Backpressure: none; en low freezes count and prescaler, load overrides en.
module ctr_updown_mod
  import ctr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               PRE_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             boundary;

  // A load restarts the prescale period so the first step after it is a full one.
  ctr_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next-state: load beats tick; a tick either steps or hits a bound.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~clr_ovf;
    boundary = 1'b0;
    if (load) begin
      // Out-of-range load values are accepted silently; the bound is
      // only evaluated on the next tick.
      count_d = load_val;
    end else if (tick) begin
      if (up == CTR_UP) begin
        if (count_q >= limit) boundary = 1'b1;
        else                  count_d  = count_q + WIDTH'(1);
      end else begin
        // Above-limit values simply walk down; only zero is a bound.
        if (count_q == '0) boundary = 1'b1;
        else               count_d  = count_q - WIDTH'(1);
      end
      if (boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;  // a fresh event beats a simultaneous clear
        if (sat == CTR_SAT) count_d = (up == CTR_UP) ? limit : '0;
        else                count_d = (up == CTR_UP) ? '0 : limit;
      end
    end
  end

  // State registers; reset drops everything at once, so no tc leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ctr_updown_mod.sv
module tb_ctr_updown_mod;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic       up;
  logic       sat;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic       clr_ovf;
  logic [7:0] count;
  logic       tc;
  logic       ovf_sticky;

  int errors = 0;
  int checks = 0;

  // Reference model state: count as a plain integer, prescaler as
  // "enabled cycles since the last step".
  int m_cnt = 0;
  int m_pre = 0;
  bit m_tc  = 1'b0;
  bit m_ovf = 1'b0;

  ctr_updown_mod #(.WIDTH(8), .PRE_W(4), .RST_VAL(8'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .up         (up),
    .sat        (sat),
    .limit      (limit),
    .prescale   (prescale),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .tc         (tc),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one rising edge, in terms of the counting rules.
  task automatic model_edge();
    int nxt;
    bit tk;
    bit bnd;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_tc = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (load) begin
      m_cnt = int'(load_val); m_pre = 0; m_tc = 1'b0;
      if (clr_ovf) m_ovf = 1'b0;
      return;
    end
    tk  = en && (m_pre >= int'(prescale));
    if (en) m_pre = tk ? 0 : m_pre + 1;
    bnd = 1'b0;
    if (tk) begin
      nxt = up ? m_cnt + 1 : m_cnt - 1;
      bnd = (nxt < 0) || (up && nxt > int'(limit));
      if (!bnd)            m_cnt = nxt;
      else if (sat)        m_cnt = up ? int'(limit) : 0;
      else                 m_cnt = up ? 0 : int'(limit);
    end
    m_tc = bnd;
    if (bnd)          m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  // One clock: the model advances on the same edge, outputs settle by +1.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    en = 1'b0; load = 1'b0; load_val = 8'd0; up = 1'b1; sat = 1'b0;
    limit = 8'd9; prescale = 4'd0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) step();
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0b want 0", tc); end
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf_sticky); end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    load = 1'b1; load_val = 8'd0; en = 1'b1; up = 1'b1; sat = 1'b0;
    limit = 8'd9; prescale = 4'd0;
    step();
    load = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++;
      if ({count, tc, ovf_sticky} !== {8'(k % 10), k == 10, k >= 10}) begin
        errors++;
        $display("FAIL wrap_up k=%0d: got cnt=%0d tc=%0b ovf=%0b want cnt=%0d tc=%0b ovf=%0b",
                 k, count, tc, ovf_sticky, k % 10, k == 10, k >= 10);
      end
    end
  endtask

  task automatic test_prescale();
    bit en_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 8'd0; en = 1'b1; up = 1'b1; sat = 1'b0;
    limit = 8'd100; prescale = 4'd3; clr_ovf = 1'b1;
    step();
    load = 1'b0; clr_ovf = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (count !== 8'(k / 4)) begin
        errors++;
        $display("FAIL prescale_period k=%0d: got %0d want %0d", k, count, k / 4);
      end
    end
    // Two idle cycles mid-period stretch it from 4 to 6 clocks.
    for (int k = 0; k < 6; k++) begin
      en = en_pat[k];
      step();
      checks++;
      if (count !== ((k == 5) ? 8'd3 : 8'd2)) begin
        errors++;
        $display("FAIL prescale_stretch k=%0d: got %0d want %0d", k, count, (k == 5) ? 3 : 2);
      end
    end
  endtask

  task automatic test_sat_down();
    int exp_c [4] = '{1, 0, 0, 0};
    bit exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 8'd2; en = 1'b1; up = 1'b0; sat = 1'b1;
    limit = 8'd9; prescale = 4'd0;
    step();
    load = 1'b0;
    checks++;
    if ({count, tc} !== {8'd2, 1'b0}) begin
      errors++; $display("FAIL sat_down_load: got cnt=%0d tc=%0b want cnt=2 tc=0", count, tc);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({count, tc} !== {8'(exp_c[k]), exp_t[k]}) begin
        errors++;
        $display("FAIL sat_down k=%0d: got cnt=%0d tc=%0b want cnt=%0d tc=%0b",
                 k, count, tc, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_load_above_limit();
    load = 1'b1; load_val = 8'd200; en = 1'b1; up = 1'b1; sat = 1'b0;
    limit = 8'd9; prescale = 4'd0;
    step();
    checks++;
    if ({count, tc} !== {8'd200, 1'b0}) begin
      errors++; $display("FAIL load200: got cnt=%0d tc=%0b want cnt=200 tc=0", count, tc);
    end
    load = 1'b0;
    step();
    checks++;
    if ({count, tc} !== {8'd0, 1'b1}) begin
      errors++; $display("FAIL load200_up: got cnt=%0d tc=%0b want cnt=0 tc=1", count, tc);
    end
    load = 1'b1;
    step();
    load = 1'b0; up = 1'b0;
    step();
    checks++;
    if ({count, tc} !== {8'd199, 1'b0}) begin
      errors++; $display("FAIL load200_down: got cnt=%0d tc=%0b want cnt=199 tc=0", count, tc);
    end
  endtask

  task automatic test_clr_ovf();
    load = 1'b1; load_val = 8'd9; en = 1'b1; up = 1'b1; sat = 1'b1;
    limit = 8'd9; prescale = 4'd0; clr_ovf = 1'b1;
    step();
    load = 1'b0;
    step();
    checks++;
    if ({count, tc, ovf_sticky} !== {8'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clr_vs_set: got cnt=%0d tc=%0b ovf=%0b want cnt=9 tc=1 ovf=1", count, tc, ovf_sticky);
    end
    en = 1'b0;
    step();
    checks++;
    if ({tc, ovf_sticky} !== 2'b00) begin
      errors++; $display("FAIL clr_alone: got tc=%0b ovf=%0b want tc=0 ovf=0", tc, ovf_sticky);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_async_rst();
    load = 1'b1; load_val = 8'd9; en = 1'b1; up = 1'b1; sat = 1'b1;
    limit = 8'd9; prescale = 4'd3;
    step();
    load = 1'b0;
    repeat (6) step();  // tick on the 4th edge, then two edges into the next period
    checks++;
    if ({count, ovf_sticky} !== {8'd9, 1'b1}) begin
      errors++; $display("FAIL pre_rst_state: got cnt=%0d ovf=%0b want cnt=9 ovf=1", count, ovf_sticky);
    end
    #2 rst = 1'b1;
    m_cnt = 0; m_pre = 0; m_tc = 1'b0; m_ovf = 1'b0;
    #1;
    checks++;
    if ({count, tc, ovf_sticky} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: got cnt=%0d tc=%0b ovf=%0b want cnt=0 tc=0 ovf=0", count, tc, ovf_sticky);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if ({count, tc} !== {8'(k / 4), 1'b0}) begin
        errors++;
        $display("FAIL post_rst_period k=%0d: got cnt=%0d tc=%0b want cnt=%0d tc=0", k, count, tc, k / 4);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      up       = ($urandom_range(0, 3) != 0) ? up : ~up;
      sat      = ($urandom_range(0, 7) == 0) ? ~sat : sat;
      clr_ovf  = ($urandom_range(0, 7) == 0);
      prescale = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       limit = 8'd0;
          1:       limit = 8'd255;
          default: limit = 8'($urandom_range(1, 20));
        endcase
      end
      step();
      checks++;
      if ({count, tc, ovf_sticky} !== {8'(m_cnt), m_tc, m_ovf}) begin
        errors++;
        $display("FAIL random k=%0d: got cnt=%0d tc=%0b ovf=%0b want cnt=%0d tc=%0b ovf=%0b",
                 k, count, tc, ovf_sticky, m_cnt, m_tc, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_prescale();
    test_sat_down();
    test_load_above_limit();
    test_clr_ovf();
    test_async_rst();
    limit = 8'd12;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
